// File: rtl/gpu_pkg.sv
// Shared GPU scene-loader definitions.
// Holds default scene widths, command-byte layout, record addressing, the
// FSM state encoding, and helpers that size and lay out a polygon record.
// Poly record layout (MSB first): enable, color, v0x, v0y, v1x, v1y, v2x, v2y.
package gpu_pkg;

    localparam int N_POLY_DEF = 2;
    localparam int WCOLOR_DEF = 6;
    localparam int WPX_DEF    = 10;
    localparam int WPY_DEF    = 9;

    localparam int CMD_READ = 7;   // command byte bit: 1 = read, 0 = write
    localparam int BG_ADDR  = 0;   // address of the 1-byte background record

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_DRAIN
    } state_t;

    // Payload bits of one polygon record.
    function automatic int rec_bits(int wc, int wx, int wy);
        return 1 + wc + 3 * (wx + wy);
    endfunction

    // Record length on the wire, padded up to whole bytes.
    function automatic int poly_bytes(int wc, int wx, int wy);
        return (rec_bits(wc, wx, wy) + 7) / 8;
    endfunction

    function automatic int off_enable(int wc, int wx, int wy);
        return wc + 3 * (wx + wy);
    endfunction

    function automatic int off_color(int wx, int wy);
        return 3 * (wx + wy);
    endfunction

    // Vertex v (0..2): v2 sits at the bottom of the record, v0 at the top.
    function automatic int off_vx(int v, int wx, int wy);
        return (2 - v) * (wx + wy) + wy;
    endfunction

    function automatic int off_vy(int v, int wx, int wy);
        return (2 - v) * (wx + wy);
    endfunction

endpackage

// File: rtl/spi_scene_loader_if.sv
// SPI bus between a host master and the scene loader.
// Signals: cs_in (active low), sck_in (mode 0), mosi_in (MSB first), miso_out.
// master: drives cs/sck/mosi and samples miso; slave: the reverse.
interface spi_scene_loader_if;
    logic cs_in;
    logic sck_in;
    logic mosi_in;
    logic miso_out;

    modport master (output cs_in, output sck_in, output mosi_in, input miso_out);
    modport slave  (input cs_in, input sck_in, input mosi_in, output miso_out);
endinterface

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain.
// Ports: clk/rst; cs_in, sck_in, mosi_in raw pins;
//        cs_s synchronised chip select, cs_rise/cs_fall and sck_rise/sck_fall
//        one-clk edge pulses, mosi_s synchronised data aligned with sck edges.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic cs_in,
    input  logic sck_in,
    input  logic mosi_in,
    output logic cs_s,
    output logic cs_rise,
    output logic cs_fall,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_s
);
    // [1:0] are the synchroniser stages, [2] remembers the previous value.
    logic [2:0] cs_q;
    logic [2:0] sck_q;
    logic [1:0] mosi_q;

    // cs resets to "selected" so a cs still held low after reset is never
    // mistaken for a fresh frame: the loader sits in DRAIN until a real rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q   <= '0;
            sck_q  <= '0;
            mosi_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the previous cycle's value of its neighbour.
            cs_q   <= {cs_q[1:0], cs_in};
            sck_q  <= {sck_q[1:0], sck_in};
            mosi_q <= {mosi_q[0], mosi_in};
        end
    end

    assign cs_s     = cs_q[1];
    assign cs_rise  =  cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] &  cs_q[2];
    assign sck_rise =  sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] &  sck_q[2];
    assign mosi_s   = mosi_q[1];
endmodule

// File: rtl/spi_scene_loader.sv
// SPI-slave scene-register front end with shadow/active double buffering.
// Ports: clk, rst (async, active high); spi (slave modport of the SPI bus);
//        en_load commits shadow -> active; *_out active scene fields, poly i
//        packed at [i*W +: W]; busy_out frame in progress; cmd_err_out
//        one-clk pulse on bad address or burst overrun.
module spi_scene_loader
    import gpu_pkg::*;
#(
    parameter int N_POLY = N_POLY_DEF,
    parameter int WCOLOR = WCOLOR_DEF,
    parameter int WPX    = WPX_DEF,
    parameter int WPY    = WPY_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_scene_loader_if.slave        spi,
    input  logic                     en_load,
    output logic [WCOLOR-1:0]        bg_color_out,
    output logic [WCOLOR*N_POLY-1:0] poly_color_out,
    output logic [WPX*N_POLY-1:0]    v0_x_out,
    output logic [WPX*N_POLY-1:0]    v1_x_out,
    output logic [WPX*N_POLY-1:0]    v2_x_out,
    output logic [WPY*N_POLY-1:0]    v0_y_out,
    output logic [WPY*N_POLY-1:0]    v1_y_out,
    output logic [WPY*N_POLY-1:0]    v2_y_out,
    output logic [N_POLY-1:0]        poly_enable_out,
    output logic                     busy_out,
    output logic                     cmd_err_out
);
    localparam int RB    = rec_bits(WCOLOR, WPX, WPY);
    localparam int REC_W = 8 * poly_bytes(WCOLOR, WPX, WPY);
    localparam int CW    = $clog2(REC_W);
    localparam int IW    = (N_POLY > 1) ? $clog2(N_POLY) : 1;
    localparam logic [6:0] MAX_ADDR = 7'(N_POLY);

    logic cs_s, cs_rise, cs_fall, sck_rise, sck_fall, mosi;

    spi_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .cs_in    (spi.cs_in),
        .sck_in   (spi.sck_in),
        .mosi_in  (spi.mosi_in),
        .cs_s     (cs_s),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .mosi_s   (mosi)
    );

    state_t            state, state_nxt;
    logic [6:0]        addr, addr_nxt, rd_addr;
    logic [CW-1:0]     cnt, cnt_nxt, last_cnt;
    logic [REC_W-1:0]  sr, sr_nxt, rd_rec;    // shared in/out shift register
    logic [7:0]        cmd_byte;
    logic              miso_q, miso_nxt, err_nxt;

    logic [WCOLOR-1:0] sh_bg, sh_bg_nxt, act_bg;
    logic [RB-1:0]     sh_poly [N_POLY];
    logic [RB-1:0]     sh_poly_nxt [N_POLY];
    logic [RB-1:0]     act_poly [N_POLY];

    assign cmd_byte = {sr[6:0], mosi};
    assign last_cnt = (addr == 7'(BG_ADDR)) ? CW'(7) : CW'(REC_W - 1);

    // Shadow record presented for readback, left-aligned in the shifter with
    // pad bits zero. In CMD it is the start address, otherwise the next one.
    always_comb begin
        rd_addr = (state == ST_CMD) ? cmd_byte[6:0] : addr + 7'd1;
        rd_rec  = '0;
        if (rd_addr == 7'(BG_ADDR))
            rd_rec[REC_W-1 -: 8] = 8'(sh_bg);
        else if (rd_addr <= MAX_ADDR)
            rd_rec[RB-1:0] = sh_poly[IW'(rd_addr - 7'd1)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_DRAIN;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt   = state;
        addr_nxt    = addr;
        cnt_nxt     = cnt;
        sr_nxt      = sr;
        miso_nxt    = miso_q;
        err_nxt     = 1'b0;
        sh_bg_nxt   = sh_bg;
        sh_poly_nxt = sh_poly;

        if (cs_rise) begin
            // Frame ends wherever it is; an unfinished record is dropped.
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (cs_fall) begin
                    state_nxt = ST_CMD;
                    cnt_nxt   = '0;
                end
                ST_CMD: if (sck_rise) begin
                    sr_nxt  = {sr[REC_W-2:0], mosi};
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(7)) begin
                        cnt_nxt  = '0;
                        addr_nxt = cmd_byte[6:0];
                        if (cmd_byte[6:0] > MAX_ADDR) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end else if (cmd_byte[CMD_READ]) begin
                            state_nxt = ST_RDATA;
                            sr_nxt    = rd_rec;
                            miso_nxt  = 1'b0;
                        end else begin
                            state_nxt = ST_WDATA;
                        end
                    end
                end
                ST_WDATA: if (sck_rise) begin
                    if (addr > MAX_ADDR) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DRAIN;
                    end else begin
                        sr_nxt  = {sr[REC_W-2:0], mosi};
                        cnt_nxt = cnt + CW'(1);
                        if (cnt == last_cnt) begin
                            cnt_nxt  = '0;
                            addr_nxt = addr + 7'd1;
                            if (addr == 7'(BG_ADDR))
                                sh_bg_nxt = {sr[WCOLOR-2:0], mosi};
                            else
                                sh_poly_nxt[IW'(addr - 7'd1)] = {sr[RB-2:0], mosi};
                        end
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        miso_nxt = sr[REC_W-1];
                        sr_nxt   = {sr[REC_W-2:0], 1'b0};
                    end else if (sck_rise) begin
                        // Master sampling a bit beyond the last record is the overrun.
                        if (addr > MAX_ADDR) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                            if (cnt == last_cnt) begin
                                cnt_nxt  = '0;
                                addr_nxt = addr + 7'd1;
                                sr_nxt   = rd_rec;
                            end
                        end
                    end
                end
                ST_DRAIN: if (cs_s) state_nxt = ST_IDLE;
                default:  state_nxt = ST_DRAIN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            cnt         <= '0;
            sr          <= '0;
            miso_q      <= 1'b0;
            cmd_err_out <= 1'b0;
            // NOTE: shadow and active banks are plain flops, not RAM, and the
            // rasteriser must see a defined scene after reset, so clear them.
            sh_bg       <= '0;
            act_bg      <= '0;
            sh_poly     <= '{default: '0};
            act_poly    <= '{default: '0};
        end else begin
            addr        <= addr_nxt;
            cnt         <= cnt_nxt;
            sr          <= sr_nxt;
            miso_q      <= miso_nxt;
            cmd_err_out <= err_nxt;
            sh_bg       <= sh_bg_nxt;
            sh_poly     <= sh_poly_nxt;
            // Commit takes the post-write shadow so a same-cycle write lands.
            if (en_load) begin
                act_bg   <= sh_bg_nxt;
                act_poly <= sh_poly_nxt;
            end
        end
    end

    assign spi.miso_out = (state == ST_RDATA) & miso_q;
    assign busy_out     = (state == ST_CMD) || (state == ST_WDATA) || (state == ST_RDATA);
    assign bg_color_out = act_bg;

    for (genvar i = 0; i < N_POLY; i++) begin : g_out
        assign poly_enable_out[i]               = act_poly[i][off_enable(WCOLOR, WPX, WPY)];
        assign poly_color_out[i*WCOLOR +: WCOLOR] = act_poly[i][off_color(WPX, WPY) +: WCOLOR];
        assign v0_x_out[i*WPX +: WPX] = act_poly[i][off_vx(0, WPX, WPY) +: WPX];
        assign v1_x_out[i*WPX +: WPX] = act_poly[i][off_vx(1, WPX, WPY) +: WPX];
        assign v2_x_out[i*WPX +: WPX] = act_poly[i][off_vx(2, WPX, WPY) +: WPX];
        assign v0_y_out[i*WPY +: WPY] = act_poly[i][off_vy(0, WPX, WPY) +: WPY];
        assign v1_y_out[i*WPY +: WPY] = act_poly[i][off_vy(1, WPX, WPY) +: WPY];
        assign v2_y_out[i*WPY +: WPY] = act_poly[i][off_vy(2, WPX, WPY) +: WPY];
    end
endmodule

// File: tb/tb_spi_scene_loader.sv
// Directed bench for spi_scene_loader at default parameters (2 polys,
// RGB222, 10-bit X, 9-bit Y, 8-byte poly records).
module tb_spi_scene_loader;
    logic clk = 1'b0;
    logic rst;
    logic en_load;
    logic [5:0]  bg_color_out;
    logic [11:0] poly_color_out;
    logic [19:0] v0_x_out, v1_x_out, v2_x_out;
    logic [17:0] v0_y_out, v1_y_out, v2_y_out;
    logic [1:0]  poly_enable_out;
    logic        busy_out, cmd_err_out;

    always #5 clk = ~clk;

    spi_scene_loader_if spi_if ();

    spi_scene_loader dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi_if),
        .en_load         (en_load),
        .bg_color_out    (bg_color_out),
        .poly_color_out  (poly_color_out),
        .v0_x_out        (v0_x_out),
        .v1_x_out        (v1_x_out),
        .v2_x_out        (v2_x_out),
        .v0_y_out        (v0_y_out),
        .v1_y_out        (v1_y_out),
        .v2_y_out        (v2_y_out),
        .poly_enable_out (poly_enable_out),
        .busy_out        (busy_out),
        .cmd_err_out     (cmd_err_out)
    );

    // Hand-packed records: {en, color, v0x, v0y, v1x, v1y, v2x, v2y}.
    // poly0: 1, 0x15, (5,7), (600,10), (300,470)
    // poly1: 1, 0x2A, (1023,511), (0,0), (512,256)
    localparam logic [63:0] REC0 = 64'hAA02_81E5_8052_59D6;
    localparam logic [63:0] REC1 = 64'hD5FF_FFC0_0004_0100;

    typedef struct {
        logic [7:0] data;
        logic [5:0] exp;
    } bg_vec_t;

    typedef struct {
        string       name;
        int          sel;
        int          poly;
        logic [15:0] exp;
    } field_vec_t;

    bg_vec_t    bg_tab [3];
    field_vec_t f_tab  [14];

    int total = 0;
    int bad = 0;
    int err_pulses = 0;

    always @(negedge clk) if (cmd_err_out === 1'b1) err_pulses++;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] field(input int sel, input int p);
        case (sel)
            0: field = 16'(poly_color_out[p*6 +: 6]);
            1: field = 16'(v0_x_out[p*10 +: 10]);
            2: field = 16'(v0_y_out[p*9 +: 9]);
            3: field = 16'(v1_x_out[p*10 +: 10]);
            4: field = 16'(v1_y_out[p*9 +: 9]);
            5: field = 16'(v2_x_out[p*10 +: 10]);
            default: field = 16'(v2_y_out[p*9 +: 9]);
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit: set mosi, sample miso just before sck rises.
    task automatic spi_bit(input logic b, output logic r);
        spi_if.mosi_in = b;
        wait_clk(6);
        r = spi_if.miso_out;
        spi_if.sck_in = 1'b1;
        wait_clk(6);
        spi_if.sck_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) spi_bit(b[i], r);
    endtask

    task automatic send_rec(input logic [63:0] rec);
        for (int i = 7; i >= 0; i--) send_byte(rec[i*8 +: 8]);
    endtask

    task automatic frame_begin();
        spi_if.cs_in = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        wait_clk(6);
        spi_if.cs_in = 1'b1;
        wait_clk(8);
    endtask

    task automatic commit();
        en_load = 1'b1;
        wait_clk(1);
        en_load = 1'b0;
        wait_clk(1);
    endtask

    task automatic spi_read(input logic [7:0] cmd, input int n, output logic [63:0] d);
        logic r;
        d = '0;
        frame_begin();
        send_byte(cmd);
        for (int i = 0; i < n; i++) begin
            spi_bit(1'b0, r);
            d = {d[62:0], r};
        end
        frame_end();
    endtask

    initial begin
        logic [63:0] rd;
        logic        r;
        int          e0;

        bg_tab[0] = '{8'h2A, 6'h2A};
        bg_tab[1] = '{8'hC5, 6'h05};   // bits above the colour are ignored
        bg_tab[2] = '{8'h00, 6'h00};

        f_tab[0]  = '{"p0_color", 0, 0, 16'h15};
        f_tab[1]  = '{"p0_v0x",   1, 0, 16'd5};
        f_tab[2]  = '{"p0_v0y",   2, 0, 16'd7};
        f_tab[3]  = '{"p0_v1x",   3, 0, 16'd600};
        f_tab[4]  = '{"p0_v1y",   4, 0, 16'd10};
        f_tab[5]  = '{"p0_v2x",   5, 0, 16'd300};
        f_tab[6]  = '{"p0_v2y",   6, 0, 16'd470};
        f_tab[7]  = '{"p1_color", 0, 1, 16'h2A};
        f_tab[8]  = '{"p1_v0x",   1, 1, 16'd1023};
        f_tab[9]  = '{"p1_v0y",   2, 1, 16'd511};
        f_tab[10] = '{"p1_v1x",   3, 1, 16'd0};
        f_tab[11] = '{"p1_v1y",   4, 1, 16'd0};
        f_tab[12] = '{"p1_v2x",   5, 1, 16'd512};
        f_tab[13] = '{"p1_v2y",   6, 1, 16'd256};

        rst = 1'b1;
        en_load = 1'b0;
        spi_if.cs_in = 1'b1;
        spi_if.sck_in = 1'b0;
        spi_if.mosi_in = 1'b0;
        wait_clk(3);
        check("rst_bg", 64'(bg_color_out), 64'h0);
        check("rst_enable", 64'(poly_enable_out), 64'h0);
        check("rst_v0x", 64'(v0_x_out), 64'h0);
        check("rst_busy", 64'(busy_out), 64'h0);
        check("rst_err", 64'(cmd_err_out), 64'h0);
        check("rst_miso", 64'(spi_if.miso_out), 64'h0);
        rst = 1'b0;
        wait_clk(8);

        // Background writes: active holds the old value until commit.
        for (int i = 0; i < 3; i++) begin
            logic [5:0] prev;
            prev = (i == 0) ? 6'h00 : bg_tab[i-1].exp;
            frame_begin();
            send_byte(8'h00);
            send_byte(bg_tab[i].data);
            frame_end();
            check($sformatf("bg_pre_commit_%0d", i), 64'(bg_color_out), 64'(prev));
            commit();
            check($sformatf("bg_commit_%0d", i), 64'(bg_color_out), 64'(bg_tab[i].exp));
        end
        // Leave shadow bg at 0x05 for the readback checks below.
        frame_begin(); send_byte(8'h00); send_byte(8'hC5); frame_end();
        commit();

        // Burst write of both polys ending exactly at the last slot.
        e0 = err_pulses;
        frame_begin();
        send_byte(8'h01);
        send_rec(REC0);
        send_rec(REC1);
        frame_end();
        check("burst_no_err", 64'(err_pulses - e0), 64'd0);
        check("burst_pre_commit_en", 64'(poly_enable_out), 64'h0);
        commit();
        for (int i = 0; i < 14; i++)
            check(f_tab[i].name, 64'(field(f_tab[i].sel, f_tab[i].poly)), 64'(f_tab[i].exp));
        check("burst_enable", 64'(poly_enable_out), 64'h3);

        spi_read(8'h81, 64, rd);
        check("read_poly0", rd, REC0);
        check("read_active_en", 64'(poly_enable_out), 64'h3);
        check("read_active_v1x", 64'(v1_x_out), {44'h0, 10'd0, 10'd600});
        spi_read(8'h00 | 8'h80, 8, rd);
        check("read_bg_pad0", rd, 64'h05);

        // Bad address: one error pulse, trailing bytes are dropped.
        e0 = err_pulses;
        frame_begin();
        send_byte(8'h05);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
        frame_end();
        check("badaddr_err", 64'(err_pulses - e0), 64'd1);
        spi_read(8'h81, 64, rd);
        check("badaddr_shadow", rd, REC0);

        // Partial record: cs rises after 3 bytes.
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_clk(6);
        spi_if.cs_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_clk(1);
            if (busy_out == 1'b0) break;
        end
        check("partial_busy_drop", 64'(busy_out), 64'h0);
        wait_clk(8);
        spi_read(8'h81, 64, rd);
        check("partial_shadow", rd, REC0);

        // Overrun: one extra byte past the last poly slot.
        e0 = err_pulses;
        frame_begin();
        send_byte(8'h02);
        send_rec(REC1);
        send_byte(8'hA5);
        frame_end();
        check("overrun_err", 64'(err_pulses - e0), 64'd1);
        spi_read(8'h82, 64, rd);
        check("overrun_shadow_p1", rd, REC1);
        check("overrun_read_no_err", 64'(err_pulses - e0), 64'd1);

        // Commit in the very cycle the final bg bit is written (bypass).
        frame_begin();
        send_byte(8'h00);
        for (int i = 7; i >= 1; i--) spi_bit(1'b1 & (i < 6 ? 1'b1 : 1'b0), r);
        spi_if.mosi_in = 1'b1;
        wait_clk(6);
        spi_if.sck_in = 1'b1;
        wait_clk(2);
        en_load = 1'b1;
        wait_clk(1);
        en_load = 1'b0;
        check("bypass_bg", 64'(bg_color_out), 64'h3F);
        wait_clk(5);
        spi_if.sck_in = 1'b0;
        frame_end();

        // Reset mid-frame with cs held low.
        e0 = err_pulses;
        frame_begin();
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
        rst = 1'b1;
        wait_clk(2);
        check("midrst_bg", 64'(bg_color_out), 64'h0);
        check("midrst_enable", 64'(poly_enable_out), 64'h0);
        check("midrst_busy", 64'(busy_out), 64'h0);
        rst = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
        send_byte(8'h00);
        send_byte(8'h11);
        check("midrst_drain_busy", 64'(busy_out), 64'h0);
        commit();
        check("midrst_no_write", 64'(bg_color_out), 64'h0);
        check("midrst_no_err", 64'(err_pulses - e0), 64'd0);
        frame_end();
        frame_begin(); send_byte(8'h00); send_byte(8'h22); frame_end();
        commit();
        check("after_rst_write", 64'(bg_color_out), 64'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
